// File: rtl/stopwatch_pkg.sv
// Shared state encoding and digit limit for the two-digit BCD stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/key_debounce.sv
// Raw active-low pushbutton -> 2-flop sync -> debounced level -> one-cycle press pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic key,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // Down-counter reloads while the synchronized level agrees with the
    // debounced level; reaching zero means DEBOUNCE_CYCLES disagreeing cycles.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= CNT_LOAD;
            press <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= CNT_LOAD;
            end else if (cnt == '0) begin
                level <= sync2;
                cnt   <= CNT_LOAD;
                press <= ~sync2;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_stopwatch_counter.sv
// Two-digit BCD stopwatch: debounced start/stop and clear keys, tick prescaler, 00..99 counter.
//   state | meaning
//   IDLE  | cleared at 00, waiting for start
//   RUN   | prescaler and digits advancing
//   PAUSE | prescaler and digits frozen, start resumes
module bcd_stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ        = 50_000_000,
    parameter int TICK_HZ         = 10,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       KEY_START,
    input  logic       KEY_CLEAR,
    output logic [3:0] BCD_ONES,
    output logic [3:0] BCD_TENS,
    output logic       RUNNING,
    output logic       WRAP
);

    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("CLK_FREQ/TICK_HZ must be at least 2");
        end
    endgenerate

    sw_state_t     state;
    sw_state_t     state_nxt;
    logic          start_evt;
    logic          clr_evt;
    logic [PW-1:0] presc;
    logic          tick;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_start (
        .clk_sys (CLOCK_50),
        .reset   (RESET),
        .key     (KEY_START),
        .press   (start_evt)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clear (
        .clk_sys (CLOCK_50),
        .reset   (RESET),
        .key     (KEY_CLEAR),
        .press   (clr_evt)
    );

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start_evt) begin
            case (state)
                IDLE:    state_nxt = RUN;
                RUN:     state_nxt = PAUSE;
                PAUSE:   state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
        // Clear overrides a coincident start.
        if (clr_evt) begin
            state_nxt = IDLE;
        end
    end

    assign tick    = (state == RUN) && (presc == PRE_LAST);
    assign RUNNING = (state == RUN);

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            presc    <= '0;
            BCD_ONES <= 4'd0;
            BCD_TENS <= 4'd0;
            WRAP     <= 1'b0;
        end else begin
            WRAP <= 1'b0;
            if (clr_evt) begin
                presc    <= '0;
                BCD_ONES <= 4'd0;
                BCD_TENS <= 4'd0;
            end else if (tick) begin
                presc <= '0;
                if (BCD_ONES == BCD_MAX) begin
                    BCD_ONES <= 4'd0;
                    if (BCD_TENS == BCD_MAX) begin
                        BCD_TENS <= 4'd0;
                        WRAP     <= 1'b1;
                    end else begin
                        BCD_TENS <= BCD_TENS + 1'b1;
                    end
                end else begin
                    BCD_ONES <= BCD_ONES + 1'b1;
                end
            end else if (state == RUN) begin
                presc <= presc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Bench for bcd_stopwatch_counter: integer-count model checked every cycle plus directed literal checks.
module tb_bcd_stopwatch_counter;

    localparam int DIV = 10;
    localparam int DB  = 4;

    logic       CLOCK_50;
    logic       RESET;
    logic       KEY_START;
    logic       KEY_CLEAR;
    logic [3:0] BCD_ONES;
    logic [3:0] BCD_TENS;
    logic       RUNNING;
    logic       WRAP;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    bcd_stopwatch_counter #(
        .CLK_FREQ        (20),
        .TICK_HZ         (2),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .KEY_START (KEY_START),
        .KEY_CLEAR (KEY_CLEAR),
        .BCD_ONES  (BCD_ONES),
        .BCD_TENS  (BCD_TENS),
        .RUNNING   (RUNNING),
        .WRAP      (WRAP)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic at_cyc(input int t);
        while (cyc < t) @(negedge CLOCK_50);
    endtask

    // Model: stopwatch value as a plain integer 0..99, a run flag, and
    // the elapsed RUN cycles within the current tick period.
    int m_count = 0;
    int m_phase = 0;
    bit m_run   = 0;
    bit m_wrap  = 0;
    bit m_valid = 0;
    bit m_s1[2];
    bit m_s2[2];
    bit m_deb[2];
    int m_stable[2];
    bit m_press[2];

    initial forever begin
        bit ps, pc;
        bit raw[2];
        @(posedge CLOCK_50);
        cyc++;
        ps = m_press[0];
        pc = m_press[1];
        raw[0] = KEY_START;
        raw[1] = KEY_CLEAR;
        if (RESET) begin
            m_valid = 1;
            m_count = 0;
            m_phase = 0;
            m_run   = 0;
            m_wrap  = 0;
            for (int k = 0; k < 2; k++) begin
                m_s1[k] = 1; m_s2[k] = 1; m_deb[k] = 1;
                m_stable[k] = 0; m_press[k] = 0;
            end
        end else begin
            m_wrap = 0;
            if (m_run) begin
                m_phase++;
                if (m_phase == DIV) begin
                    m_phase = 0;
                    m_count++;
                    if (m_count == 100) begin
                        m_count = 0;
                        m_wrap  = 1;
                    end
                end
            end
            if (pc) begin
                m_run = 0; m_count = 0; m_phase = 0; m_wrap = 0;
            end else if (ps) begin
                m_run = !m_run;
            end
            for (int k = 0; k < 2; k++) begin
                m_press[k] = 0;
                if (m_s2[k] != m_deb[k]) begin
                    m_stable[k]++;
                    if (m_stable[k] == DB) begin
                        m_deb[k]    = m_s2[k];
                        m_stable[k] = 0;
                        m_press[k]  = !m_s2[k];
                    end
                end else begin
                    m_stable[k] = 0;
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = raw[k];
            end
        end
    end

    initial forever begin
        @(negedge CLOCK_50);
        if (m_valid) begin
            check("model_ones", int'(BCD_ONES), m_count % 10);
            check("model_tens", int'(BCD_TENS), m_count / 10);
            check("model_running", int'(RUNNING), int'(m_run));
            check("model_wrap", int'(WRAP), int'(m_wrap));
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int l, s, r0, w0, x, y, z, last, wraps, wrap_at;
        logic [3:0] prev;
        RESET     = 1'b1;
        KEY_START = 1'b1;
        KEY_CLEAR = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        RESET = 1'b0;

        // reset state, then idle hold
        check("rst_ones", int'(BCD_ONES), 0);
        check("rst_tens", int'(BCD_TENS), 0);
        check("rst_running", int'(RUNNING), 0);
        check("rst_wrap", int'(WRAP), 0);
        at_cyc(cyc + 100);
        check("idle_ones", int'(BCD_ONES), 0);
        check("idle_running", int'(RUNNING), 0);

        // bouncing start press
        s = cyc;
        KEY_START = 1'b0;
        at_cyc(s + 2); KEY_START = 1'b1;
        at_cyc(s + 3); KEY_START = 1'b0;
        l = cyc;
        at_cyc(l + 6);
        check("start_latency_before", int'(RUNNING), 0);
        at_cyc(l + 7);
        check("start_latency_at", int'(RUNNING), 1);

        // count with release along the way
        last = l + 7;
        prev = BCD_ONES;
        for (int t = l + 8; t <= l + 157; t++) begin
            at_cyc(t);
            if (t == l + 22) KEY_START = 1'b1;
            if (t == l + 40) check("release_no_event", int'(RUNNING), 1);
            if (BCD_ONES != prev) begin
                check("tick_spacing", t - last, DIV);
                last = t;
                prev = BCD_ONES;
            end
        end
        check("count150_ones", int'(BCD_ONES), 5);
        check("count150_tens", int'(BCD_TENS), 1);

        // clear during RUN at 42
        at_cyc(l + 425); KEY_CLEAR = 1'b0;
        at_cyc(l + 431);
        check("pre_clear_ones", int'(BCD_ONES), 2);
        check("pre_clear_tens", int'(BCD_TENS), 4);
        at_cyc(l + 432);
        check("clear_ones", int'(BCD_ONES), 0);
        check("clear_tens", int'(BCD_TENS), 0);
        check("clear_running", int'(RUNNING), 0);
        at_cyc(l + 433); KEY_CLEAR = 1'b1;

        // pause at 07 with 6 cycles into the period, then resume
        s = l + 460;
        at_cyc(s);      KEY_START = 1'b0;
        at_cyc(s + 8);  KEY_START = 1'b1;
        at_cyc(s + 76); KEY_START = 1'b0;
        at_cyc(s + 82);
        check("pause_pre_running", int'(RUNNING), 1);
        check("pause_pre_ones", int'(BCD_ONES), 7);
        at_cyc(s + 83);
        check("pause_running", int'(RUNNING), 0);
        at_cyc(s + 84); KEY_START = 1'b1;
        at_cyc(s + 133);
        check("pause_hold_ones", int'(BCD_ONES), 7);
        check("pause_hold_tens", int'(BCD_TENS), 0);
        r0 = s + 140;
        at_cyc(r0);     KEY_START = 1'b0;
        at_cyc(r0 + 7);
        check("resume_running", int'(RUNNING), 1);
        at_cyc(r0 + 8); KEY_START = 1'b1;
        at_cyc(r0 + 10);
        check("resume_before_08", int'(BCD_ONES), 7);
        at_cyc(r0 + 11);
        check("resume_08", int'(BCD_ONES), 8);

        at_cyc(r0 + 20); KEY_CLEAR = 1'b0;
        at_cyc(r0 + 27);
        check("clear2_ones", int'(BCD_ONES), 0);
        at_cyc(r0 + 28); KEY_CLEAR = 1'b1;

        // full wrap from 00
        w0 = r0 + 40;
        at_cyc(w0);     KEY_START = 1'b0;
        at_cyc(w0 + 8); KEY_START = 1'b1;
        wraps = 0;
        wrap_at = 0;
        for (int t = w0 + 9; t <= w0 + 1012; t++) begin
            at_cyc(t);
            if (t == w0 + 1006) begin
                check("pre_wrap_ones", int'(BCD_ONES), 9);
                check("pre_wrap_tens", int'(BCD_TENS), 9);
            end
            if (WRAP) begin
                wraps++;
                wrap_at = t;
                check("wrap_ones", int'(BCD_ONES), 0);
                check("wrap_tens", int'(BCD_TENS), 0);
            end
        end
        check("wrap_count", wraps, 1);
        check("wrap_cycle", wrap_at - w0, 1007);
        check("wrap_running", int'(RUNNING), 1);

        // pause, then start and clear together
        at_cyc(w0 + 1020); KEY_START = 1'b0;
        at_cyc(w0 + 1028); KEY_START = 1'b1;
        x = w0 + 1050;
        at_cyc(x); KEY_START = 1'b0; KEY_CLEAR = 1'b0;
        at_cyc(x + 6);
        check("paused_ones", int'(BCD_ONES), 2);
        check("paused_tens", int'(BCD_TENS), 0);
        check("paused_running", int'(RUNNING), 0);
        at_cyc(x + 7);
        check("both_ones", int'(BCD_ONES), 0);
        check("both_running", int'(RUNNING), 0);
        at_cyc(x + 8); KEY_START = 1'b1; KEY_CLEAR = 1'b1;
        y = x + 20;
        at_cyc(y); KEY_START = 1'b0;
        at_cyc(y + 7);
        check("restart_running", int'(RUNNING), 1);
        at_cyc(y + 8); KEY_START = 1'b1;
        at_cyc(y + 16);
        check("first_period_before", int'(BCD_ONES), 0);
        at_cyc(y + 17);
        check("first_period_at", int'(BCD_ONES), 1);

        // reset mid-count and mid-debounce discards the pending press
        z = y + 40;
        at_cyc(z); KEY_START = 1'b0;
        at_cyc(z + 3); RESET = 1'b1;
        at_cyc(z + 4); RESET = 1'b0; KEY_START = 1'b1;
        at_cyc(z + 5);
        check("midrst_ones", int'(BCD_ONES), 0);
        check("midrst_running", int'(RUNNING), 0);
        at_cyc(z + 25);
        check("midrst_no_press", int'(RUNNING), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
